// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// hi/lo bus layout and FSM state encoding.
package hilo_muldiv_ctrl_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int HL_BUS_WD = 66;
    localparam int HL_HI_WE  = 65;
    localparam int HL_LO_WE  = 64;
    localparam int HL_HI_MSB = 63;
    localparam int HL_HI_LSB = 32;
    localparam int HL_LO_MSB = 31;
    localparam int HL_LO_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_iter.sv
// Combinational datapath: operand sign stripping, one shift-add / restoring
// divide step, and sign restoration of the final step's result.
module muldiv_iter
    import hilo_muldiv_ctrl_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] mag_a,
    output logic [31:0] mag_b,
    output logic        sign_a,
    output logic        sign_b,
    input  logic        is_div,
    input  logic [63:0] acc_in,
    input  logic [63:0] opa_in,
    input  logic [31:0] opb_in,
    output logic [63:0] acc_out,
    output logic [63:0] opa_out,
    output logic [31:0] opb_out,
    input  logic        sign_a_q,
    input  logic        sign_b_q,
    input  logic        b_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [32:0] rem_shift;
    logic [33:0] diff;
    logic [63:0] prod;
    logic        neg_q;

    always_comb begin
        sign_a = op_is_signed(op) & src_a[31];
        sign_b = op_is_signed(op) & src_b[31];
        mag_a  = sign_a ? -src_a : src_a;
        mag_b  = sign_b ? -src_b : src_b;
    end

    // Divide: acc holds the partial remainder, opa shifts the dividend out
    // of its MSB while quotient bits enter at the LSB.
    always_comb begin
        acc_out   = acc_in;
        opa_out   = opa_in;
        opb_out   = opb_in;
        rem_shift = '0;
        diff      = '0;
        if (!is_div) begin
            if (opb_in[0]) begin
                acc_out = acc_in + opa_in;
            end
            opa_out = opa_in << 1;
            opb_out = opb_in >> 1;
        end else begin
            rem_shift = {acc_in[31:0], opa_in[31]};
            diff      = {1'b0, rem_shift} - {2'b00, opb_in};
            if (!diff[33]) begin
                acc_out = {31'b0, diff[32:0]};
                opa_out = {32'b0, opa_in[30:0], 1'b1};
            end else begin
                acc_out = {31'b0, rem_shift};
                opa_out = {32'b0, opa_in[30:0], 1'b0};
            end
        end
    end

    // A zero divisor leaves an all-ones quotient that must not be negated;
    // the remainder then equals the raw dividend once its sign is restored.
    assign neg_q = (sign_a_q ^ sign_b_q) & ~(is_div & b_zero);

    always_comb begin
        prod = neg_q ? -acc_out : acc_out;
        if (!is_div) begin
            hi = prod[63:32];
            lo = prod[31:0];
        end else begin
            lo = neg_q    ? -opa_out[31:0] : opa_out[31:0];
            hi = sign_a_q ? -acc_out[31:0] : acc_out[31:0];
        end
    end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer: stalls EX while running and issues
// one registered HI/LO write when the 32-step loop completes.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int ITER = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [31:0]          src_a,
    input  logic [31:0]          src_b,
    input  logic                 flush,
    output logic                 stallreq,
    output logic                 busy,
    output logic [HL_BUS_WD-1:0] hl_bus
);

    state_t              state;
    state_t              state_nxt;
    logic [5:0]          cnt;
    logic                is_div_q;
    logic                sign_a_q;
    logic                sign_b_q;
    logic                b_zero_q;
    logic [63:0]         acc_q;
    logic [63:0]         opa_q;
    logic [31:0]         opb_q;
    logic [HL_BUS_WD-1:0] hl_q;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        sign_a;
    logic        sign_b;
    logic [63:0] acc_nxt;
    logic [63:0] opa_nxt;
    logic [31:0] opb_nxt;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        accept;
    logic        last_iter;

    assign accept    = (state == ST_IDLE) && start && !flush;
    assign last_iter = (state == ST_RUN) && (cnt == 6'(ITER - 1));

    muldiv_iter u_iter (
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .sign_a   (sign_a),
        .sign_b   (sign_b),
        .is_div   (is_div_q),
        .acc_in   (acc_q),
        .opa_in   (opa_q),
        .opb_in   (opb_q),
        .acc_out  (acc_nxt),
        .opa_out  (opa_nxt),
        .opb_out  (opb_nxt),
        .sign_a_q (sign_a_q),
        .sign_b_q (sign_b_q),
        .b_zero   (b_zero_q),
        .hi       (res_hi),
        .lo       (res_lo)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_RUN;
                ST_RUN:  if (last_iter) state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // stallreq releases in DONE so EX advances while the write is on the bus.
    always_comb begin
        busy     = (state != ST_IDLE);
        stallreq = 1'b0;
        case (state)
            ST_IDLE: stallreq = start && !flush;
            ST_RUN:  stallreq = !flush;
            default: stallreq = 1'b0;
        endcase
        hl_bus = flush ? '0 : hl_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
        end else if (accept) begin
            cnt      <= '0;
            is_div_q <= op_is_div(op);
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            b_zero_q <= (src_b == 32'd0);
            acc_q    <= '0;
            opa_q    <= {32'b0, mag_a};
            opb_q    <= mag_b;
        end else if (state == ST_RUN) begin
            cnt      <= cnt + 6'd1;
            acc_q    <= acc_nxt;
            opa_q    <= opa_nxt;
            opb_q    <= opb_nxt;
        end
    end

    // The result is captured on the last step so the bus is valid for
    // exactly the DONE cycle and zero everywhere else.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hl_q <= '0;
        end else if (last_iter && !flush) begin
            hl_q <= {2'b11, res_hi, res_lo};
        end else begin
            hl_q <= '0;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized bench for hilo_muldiv_ctrl against an arithmetic reference model.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stallreq;
    logic        busy;
    logic [65:0] hl_bus;

    logic [63:0] exp_q[$];
    int tests;
    int fails;
    int wr_seen;
    int n_pushed;

    hilo_muldiv_ctrl dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .stallreq (stallreq),
        .busy     (busy),
        .hl_bus   (hl_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                                input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (o)
            OP_MULT: begin
                p = sa * sb;
                res = p;
            end
            OP_MULTU: res = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFFFFFF};
                end else if (o == OP_DIV) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    always @(negedge clk) begin
        if (resetn && hl_bus[65:64] != 2'b00) begin
            wr_seen++;
            check("we_bits", hl_bus[65:64], 2'b11);
            check("wr_pending", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                check("hilo", hl_bus[63:0], exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issues an op in the current cycle and watches its whole lifetime.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold);
        int wr_cyc;
        int wr_n;
        int stall_bad;
        int busy_bad;
        exp_q.push_back(ref_result(o, a, b));
        n_pushed++;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        #1;
        check("stall_accept", stallreq, 1);
        wr_cyc = -1;
        wr_n = 0;
        stall_bad = 0;
        busy_bad = 0;
        for (int c = 1; c <= 36; c++) begin
            cyc();
            if (!hold || c >= 34) start = 1'b0;
            if (c == 1) begin
                src_a = $urandom;
                src_b = $urandom;
            end
            #1;
            if (hl_bus[65:64] != 2'b00) begin
                wr_n++;
                if (wr_cyc < 0) wr_cyc = c;
            end
            if ((c <= 32) != stallreq) stall_bad++;
            if ((c <= 33) != busy) busy_bad++;
        end
        check("wr_cycle", wr_cyc, 33);
        check("wr_count", wr_n, 1);
        check("stall_profile", stall_bad, 0);
        check("busy_profile", busy_bad, 0);
    endtask

    initial begin
        int wr_before;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        tests = 0;
        fails = 0;
        wr_seen = 0;
        n_pushed = 0;
        resetn = 1'b0;
        start = 1'b0;
        op = 2'b00;
        src_a = '0;
        src_b = '0;
        flush = 1'b0;
        #1;
        check("rst_hl_bus", hl_bus, 0);
        check("rst_stall", stallreq, 0);
        check("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(OP_MULT,  32'hFFFFFFFD, 32'd5,        1'b0);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0);
        run_op(OP_DIVU,  32'd100,      32'd7,        1'b0);
        run_op(OP_DIVU,  32'd7,        32'd0,        1'b0);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(OP_DIV,   32'hFFFFFFF3, 32'd0,        1'b0);
        run_op(OP_MULT,  32'h80000000, 32'h80000000, 1'b1);

        // Flush mid-divide, then a fresh op two cycles later.
        start = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            start = 1'b0;
            if (c == 10) flush = 1'b1;
            if (c == 11) flush = 1'b0;
            #1;
            if (c == 10) check("stall_flush", stallreq, 0);
            if (c == 11) check("busy_after_flush", busy, 0);
        end
        cyc();
        run_op(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0);

        // Flush landing on the DONE cycle suppresses the write.
        wr_before = wr_seen;
        start = 1'b1; op = OP_DIVU; src_a = 32'd55; src_b = 32'd4;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            start = 1'b0;
            flush = (c == 33);
            #1;
            if (c == 33) begin
                check("flush_done_we", hl_bus[65:64], 0);
                check("flush_done_stall", stallreq, 0);
            end
            if (c == 34) check("flush_done_busy", busy, 0);
        end
        check("flush_done_nowrite", wr_seen - wr_before, 0);

        // Asynchronous reset mid-multiply discards the op.
        wr_before = wr_seen;
        start = 1'b1; op = OP_MULT; src_a = 32'd77; src_b = 32'd99;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        check("rst_mid_hl_bus", hl_bus, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_stall", stallreq, 0);
        cyc();
        resetn = 1'b1;
        for (int c = 0; c < 40; c++) cyc();
        check("rst_mid_nowrite", wr_seen - wr_before, 0);
        check("rst_mid_idle", busy, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        check("queue_drained", exp_q.size(), 0);
        check("total_writes", wr_seen, n_pushed);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Iterative multiply/divide sequencer that owns all HI/LO updates for MULT/MULTU/DIV/DIVU.
- Accepts one operation from EX and runs a 32-iteration shift-add or restoring-divide loop.
- Holds the pipeline via a stall request while it runs.
- Emits a single-cycle HI/LO write on the 66-bit hi/lo bus format {hi_we, lo_we, hi[31:0], lo[31:0]}. That bus feeds both the HI/LO write port and the EX-stage HI/LO forwarding path.

Parameters:
ITER, 32, number of loop iterations (equals the operand width; the counter is 6 bits).

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset; the block uses one clock, and reset is asynchronous and active-low
start  in  1  EX presents a mul/div op this cycle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  32  rs value (multiplicand / dividend)
src_b  in  32  rt value (multiplier / divisor)
flush  in  1  pipeline flush (exception/eret); aborts the operation in flight
stallreq  out  1  hold IF/ID/EX stages
busy  out  1  FSM is not in IDLE
hl_bus  out  66  {hi_we, lo_we, hi, lo}; hi_we = lo_we = 1 for exactly one cycle per completed op

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, counter=0, all datapath registers 0.
  - hl_bus=0, stallreq=0, busy=0.
  - Reset mid-operation discards the op; no write is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 && flush=0: latch op, |src_a|, |src_b| (magnitudes for signed ops, raw values for unsigned) and the sign flags. Go to RUN, counter=0.
  - stallreq = start && !flush (combinational) in this cycle.
- RUN:
  - Performs one iteration per cycle; counter increments.
  - When counter == ITER-1, go to DONE.
  - stallreq=1 and busy=1 throughout.
- DONE:
  - Drive hl_bus we bits = 11 with the final hi/lo.
  - stallreq=0, so EX advances this cycle; next state IDLE.
- Latency: start sampled at edge 0 → hl_bus valid in cycle 33 (1 + 32 RUN cycles). Back-to-back ops are accepted from IDLE only, so the next start is taken no earlier than cycle 34.
- start while busy: ignored. EX is stalled, so it holds start; this is not an error.
- flush:
  - In any state, the next state is IDLE.
  - In DONE, hl_bus we bits are forced to 0 in that same cycle, so a flushed op never writes.
  - stallreq drops in the flush cycle.
- Multiply:
  - Unsigned 64-bit shift-add: 64-bit accumulator, multiplier shifted right 1 per iteration.
  - Signed: the magnitude product is negated (two's complement, 64-bit) when sign_a ^ sign_b.
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - Restoring algorithm: 33-bit partial remainder, quotient shifted in LSB-first.
  - Signed: the quotient is negated when sign_a ^ sign_b; the remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
  - 0x80000000 / -1 (signed): lo = 0x80000000, hi = 0 (natural wrap, no trap).
- Divide by zero (src_b == 0): still runs the full 32 cycles. Result is lo = 0xFFFFFFFF, hi = src_a (raw operand), for both DIV and DIVU.
- hl_bus is registered; its value outside DONE is all zeros.

Decomposition:
- Shared package defines:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the HL_BUS_WD = 66 constant and its field positions (hi_we 65, lo_we 64, hi 63:32, lo 31:0);
  - state encodings.
- One sub-module, muldiv_iter: the combinational single-iteration step (add-or-skip / subtract-or-restore) plus the sign pre/post correction. The FSM, counter and registers stay in hilo_muldiv_ctrl.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → at cycle 33: hi=0xFFFFFFFE, lo=0x00000001, we=11 for one cycle; stallreq high cycles 0–32, low at 33.
- MULT 0xFFFFFFFD (−3) × 5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) / 2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU 100/7 → lo=14, hi=2.
- DIVU 7 / 0 → lo=0xFFFFFFFF, hi=0x00000007 after 33 cycles; DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- flush asserted at cycle 10 of a DIV → stallreq low in that cycle, busy low next cycle, no hl_bus write ever. A new start at cycle 12 completes normally at cycle 45.
- resetn pulsed low at cycle 20 of a MULT → all outputs 0 immediately (async); start held high throughout a busy op → only one write observed.
